// File: rtl/qspi_fifo_pkg.sv
// Shared definitions for the QSPI FIFO family: default geometry, lane order,
// and the helper that sizes level/pack-count fields.
package qspi_fifo_pkg;

  // Lane 0 lands in the least significant bits of a packed word.
  localparam bit LANE_ORDER_LE = 1'b1;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_LANE  = 8;
  localparam int DEF_DEPTH = 16;

  // Bits needed to hold a count in 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/qspi_rx_lane_packer.sv
// Lane accumulator: gathers LANE-bit lanes into a WIDTH-bit word and issues a
// one-cycle write strobe when the word is full or the transfer ends early.
module qspi_rx_lane_packer
  import qspi_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANE  = DEF_LANE
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                flush,
  input  logic                                push,
  input  logic [LANE-1:0]                     data,
  input  logic                                last,
  output logic                                wr_en,
  output logic [WIDTH-1:0]                    wr_data,
  output logic [cnt_width(WIDTH/LANE)-1:0]    pack_cnt
);

  localparam int NL = WIDTH / LANE;
  localparam int PW = cnt_width(NL);

  logic [WIDTH-1:0] acc;
  logic [PW-1:0]    cnt;
  logic [PW-1:0]    lane_idx;
  logic [WIDTH-1:0] lane_word;
  logic             last_lane;

  // acc keeps unfilled lanes at zero, so an early in_last word is padded for free.
  always_comb begin
    lane_idx  = LANE_ORDER_LE ? cnt : (PW'(NL - 1) - cnt);
    lane_word = WIDTH'(data) << (lane_idx * LANE);
    last_lane = (cnt == PW'(NL - 1));
    wr_en     = push & ~flush & (last_lane | last);
    wr_data   = acc | lane_word;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc <= '0;
      cnt <= '0;
    end else if (flush) begin
      acc <= '0;
      cnt <= '0;
    end else if (push) begin
      if (wr_en) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= wr_data;
        cnt <= cnt + PW'(1);
      end
    end
  end

  assign pack_cnt = cnt;

endmodule

// File: rtl/qspi_rx_pack_fifo.sv
// QSPI RX FIFO: packs shifter lanes into words and buffers DEPTH words.
// Define QSPI_RX_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module qspi_rx_pack_fifo
  import qspi_fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LANE     = DEF_LANE,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 4
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              flush_i,
  input  logic                              in_valid_i,
  input  logic [LANE-1:0]                   in_data_i,
  input  logic                              in_last_i,
  output logic                              in_ready_o,
  input  logic                              rd_en_i,
  output logic [WIDTH-1:0]                  rd_data_o,
  output logic                              rd_valid_o,
  output logic                              empty_o,
  output logic                              full_o,
  output logic                              almost_full_o,
  output logic [cnt_width(DEPTH)-1:0]       level_o,
  output logic [cnt_width(WIDTH/LANE)-1:0]  pack_cnt_o,
  output logic                              ovf_o,
  output logic                              udf_o,
  input  logic                              clr_err_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = cnt_width(DEPTH);

  // Handshake: a lane transfers on a rising edge where in_valid_i and in_ready_o
  // are both high; in_ready_o comes from registered state only, so it never
  // depends on in_valid_i. A pop transfers when rd_en_i is high and empty_o is low.

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             push;
  logic             pop;
  logic             pk_wr;
  logic [WIDTH-1:0] pk_data;
  logic             ovf_set;
  logic             udf_set;

  assign full_o        = (count == LW'(DEPTH));
  assign empty_o       = (count == '0);
  assign almost_full_o = (count >= LW'(AF_LEVEL));
  assign level_o       = count;
  assign in_ready_o    = ~full_o;

  assign push    = in_valid_i & in_ready_o;
  assign pop     = rd_en_i & ~empty_o;
  assign ovf_set = in_valid_i & full_o;
  assign udf_set = rd_en_i & empty_o;

  qspi_rx_lane_packer #(
    .WIDTH (WIDTH),
    .LANE  (LANE)
  ) u_packer (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (flush_i),
    .push     (push),
    .data     (in_data_i),
    .last     (in_last_i),
    .wr_en    (pk_wr),
    .wr_data  (pk_data),
    .pack_cnt (pack_cnt_o)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_o  <= 1'b0;
      udf_o  <= 1'b0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_o  <= 1'b0;
      udf_o  <= 1'b0;
    end else begin
      if (pk_wr) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({pk_wr, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
      // A set event in the same cycle as clr_err_i wins.
      ovf_o <= ovf_set | (ovf_o & ~clr_err_i);
      udf_o <= udf_set | (udf_o & ~clr_err_i);
    end
  end

  // pk_wr only fires while not full, so a write never lands on unread data.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!flush_i && pk_wr) begin
      mem[wr_ptr] <= pk_data;
    end
  end

`ifdef QSPI_RX_FIFO_FWFT_EN
  assign rd_data_o  = empty_o ? '0 : mem[rd_ptr];
  assign rd_valid_o = ~empty_o;
`else
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (flush_i) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= pop;
      if (pop) rd_data_q <= mem[rd_ptr];
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
`endif

endmodule

// File: doc/qspi_rx_pack_fifo.md
# qspi_rx_pack_fifo

Parametrised next-generation RX FIFO for the QSPI controller datapath. It sits between the QSPI shift engine and the register/bus read port. It accepts narrow lanes (bytes by default) from the shifter, packs them little-endian into WIDTH-bit words, and buffers DEPTH words. Compared with the plain word FIFO it adds a programmable almost-full flag, explicit end-of-transfer packing, flush, sticky overflow/underflow error flags, and a compile-time first-word-fall-through read mode.

## Interface
- WIDTH, 32: storage word width; integer multiple of LANE.
- LANE, 8: input lane width; NL = WIDTH/LANE lanes per word.
- DEPTH, 16: words of storage; power of two, at least 2.
- AF_LEVEL, DEPTH-4: almost_full_o asserts when level_o >= AF_LEVEL; range 1..DEPTH.
- clk  in  1  sole clock; all logic on its rising edge.
- resetn  in  1  reset; synchronous and active-low.
- flush_i  in  1  synchronous clear of packer, storage and flags.
- in_valid_i  in  1  lane push request.
- in_data_i  in  LANE  lane data.
- in_last_i  in  1  qualifies push as final lane of a transfer.
- in_ready_o  out  1  push accepted when high; equals !full_o.
- rd_en_i  in  1  pop request.
- rd_data_o  out  WIDTH  read data.
- rd_valid_o  out  1  rd_data_o is valid this cycle.
- empty_o, full_o, almost_full_o  out  1 each  storage status.
- level_o  out  $clog2(DEPTH)+1  words held in storage; partially packed words are excluded.
- pack_cnt_o  out  $clog2(NL)+1  lanes held in the packer, 0..NL-1.
- ovf_o, udf_o  out  1 each  sticky overflow and underflow flags.
- clr_err_i  in  1  clears ovf_o and udf_o.

## Operation
- Reset (resetn=0 at an edge) takes priority over all other inputs. After reset: pointers, level_o, pack_cnt_o, ovf_o, udf_o, rd_valid_o and rd_data_o are 0; empty_o=1; full_o=0; almost_full_o=0; in_ready_o=1.
- flush_i is next in priority. It gives the same result as reset, with two exceptions: memory contents are not cleared, and any push or pop presented in the same cycle is ignored.
- Push is accepted when in_valid_i && in_ready_o.
  - Lane k (0-based) goes to bits [k*LANE +: LANE] of the word being packed.
  - When lane NL-1 is accepted, the word is written to storage and pack_cnt returns to 0.
  - When a push is accepted with in_last_i=1, the word is written with the unfilled upper lanes zeroed, and pack_cnt returns to 0. If NL=1, in_last_i has no effect.
- Push presented while in_ready_o=0: the lane is dropped, ovf_o is set, and packer state is unchanged.
- Pop is accepted when rd_en_i && !empty_o; rd_ptr advances.
- Pop presented while empty_o=1: ignored, udf_o is set.
- Flags:
  - ovf_o and udf_o stay set until clr_err_i or flush_i.
  - If a set event and clr_err_i occur in the same cycle, the set wins.
- level_o:
  - A storage write and an accepted pop in the same cycle leave level_o unchanged.
  - level_o cannot exceed DEPTH, because writes are blocked when full.
  - Pointers wrap modulo DEPTH.
- Full while popping: in_ready_o is derived from the registered full_o. A push in the same cycle as a pop from a full FIFO is therefore refused; there is no bypass.

## Timing
- A word-completing push at edge t gives level_o+1, empty_o=0 and updated full_o/almost_full_o from cycle t+1.
- All status outputs are registered, or decoded from registered count only.
- Non-FWFT read (default):
  - Pop accepted at edge t: rd_data_o = stored word and rd_valid_o=1 in cycle t+1.
  - rd_valid_o is a one-cycle pulse per pop.
  - rd_data_o holds its last value otherwise.
- FWFT read: described under Configuration.
- Minimum write-to-read latency is 1 cycle (FWFT) or 2 cycles (non-FWFT) from the completing push edge.
- Sustained throughput: one lane push and one word pop per cycle.

## Configuration
- Macro: QSPI_RX_FIFO_FWFT_EN.
- Defined:
  - rd_data_o = mem[rd_ptr] when !empty_o, else 0; this path is combinational from registered state.
  - rd_valid_o = !empty_o.
  - Pop consumes the presented word at the edge.
- Undefined: registered read as described under Timing. Software-visible ordering and flag behaviour are identical in both modes.

## Structure
- Shared package qspi_fifo_pkg holds:
  - the lane-order constant (little-endian);
  - default WIDTH, LANE and DEPTH localparams;
  - a width helper function used for level and pack-count widths.
- Sub-module qspi_rx_lane_packer holds the lane accumulator, pack_cnt and the in_last zero-padding. It outputs a word-write strobe and data to the storage logic in the top module.

## Test plan
- Reset/flush: drive resetn low for 2 cycles with rd_en_i and in_valid_i high -> all outputs at reset values. Push 3 lanes, then flush_i -> pack_cnt_o=0, level_o=0, empty_o=1.
- Packing: push bytes 0x11,0x22,0x33,0x44, then pop -> word 0x44332211. In non-FWFT, rd_valid_o rises one cycle after rd_en_i.
- Partial last: push 0xAA, then 0xBB with in_last_i=1 -> stored word 0x0000BBAA, pack_cnt_o=0.
- Fill and overflow: push 64 lanes (16 words), then 1 more -> full_o=1 and almost_full_o=1 (asserted from level 12), in_ready_o=0, ovf_o=1, level_o=16. Then pop everything -> data 0..15 in order.
- Underflow and clear: with empty_o=1, pop -> udf_o=1. Assert clr_err_i together with another empty pop -> udf_o stays 1. clr_err_i alone -> udf_o=0.
- Wrap and concurrency: keep level at 8 while doing simultaneous word-complete and pop for 40 cycles -> level_o constant at 8, data ordering preserved across pointer wrap. Repeat with QSPI_RX_FIFO_FWFT_EN defined.
